// File: rtl/tdm_rx_pkg.sv
// Shared types and constants for the TDM/I2S serial audio receiver.
package tdm_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    HOLD
  } state_e;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_LJ  = 1'b1;

  localparam int unsigned MAX_CHANNELS = 8;

endpackage

// File: rtl/tdm_receiver_if.sv
// Bundle of the serial audio lines and the decoded word outputs of tdm_receiver.
// frame_err exists only when TDM_FRAME_CHECK_EN is defined.
interface tdm_receiver_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned CH_W = $clog2(CHANNELS);

  logic              bck;
  logic              lrck;
  logic              sdata;
  logic              mode;
  logic [DATA_W-1:0] data;
  logic [CH_W-1:0]   ch;
  logic              data_stb;
`ifdef TDM_FRAME_CHECK_EN
  logic              frame_err;
`endif

  // master sources the serial stream, slave is the receiver
  modport master (
    output bck, lrck, sdata, mode,
    input  data, ch, data_stb
`ifdef TDM_FRAME_CHECK_EN
    , input frame_err
`endif
  );

  modport slave (
    input  bck, lrck, sdata, mode,
    output data, ch, data_stb
`ifdef TDM_FRAME_CHECK_EN
    , output frame_err
`endif
  );

endinterface

// File: rtl/bck_edge_det.sv
// Rising-edge detector for the (already synchronised) bit clock.
module bck_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bck_i,
  output logic rise_o
);

  logic bck_q;
  logic bck_qq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bck_q  <= 1'b0;
      bck_qq <= 1'b0;
    end else begin
      bck_q  <= bck_i;
      bck_qq <= bck_q;
    end
  end

  assign rise_o = bck_q & ~bck_qq;

endmodule

// File: rtl/tdm_receiver.sv
// I2S / left-justified TDM receiver: deserialises CHANNELS slots per LRCK frame.
// Optional frame checking (frame_err_o) is built when TDM_FRAME_CHECK_EN is defined.
module tdm_receiver
  import tdm_rx_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        bck_i,
  input  logic                        lrck_i,
  input  logic                        sdata_i,
  input  logic                        mode_i,
  output logic [DATA_W-1:0]           data_o,
  output logic [$clog2(CHANNELS)-1:0] ch_o,
  output logic                        data_stb_o
`ifdef TDM_FRAME_CHECK_EN
  ,
  output logic                        frame_err_o
`endif
);

  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned BIT_W = $clog2(SLOT_W);
  localparam int unsigned HALF  = CHANNELS / 2;

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS || (CHANNELS % 2) != 0 ||
      SLOT_W < 16 || SLOT_W > 32 || DATA_W < 1 || DATA_W > SLOT_W) begin : g_bad_params
    $error("tdm_receiver: unsupported CHANNELS/SLOT_W/DATA_W combination");
  end

  state_e            state_q, state_d;
  logic              lrck_q, lrck_d;
  logic              half_q, half_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              stb_q, stb_d;

  logic              rise;
  logic              lrck_edge;
  logic              capture;
  logic [DATA_W-1:0] shift_word;

  bck_edge_det u_bck_edge_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bck_i  (bck_i),
    .rise_o (rise)
  );

  assign lrck_edge  = rise && (lrck_i != lrck_q);
  assign capture    = 32'(bit_cnt_q) < DATA_W;
  assign shift_word = DATA_W'({shreg_q, sdata_i});

  // Next-state: every LRCK edge restarts the half-frame, dropping any partial slot.
  always_comb begin
    state_d    = state_q;
    lrck_d     = lrck_q;
    half_d     = half_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    ch_d       = ch_q;
    stb_d      = 1'b0;

    if (rise) begin
      lrck_d = lrck_i;
      if (lrck_edge) begin
        half_d     = lrck_i;
        slot_cnt_d = '0;
        if (mode_i == MODE_LJ) begin
          state_d   = SHIFT;
          shreg_d   = shift_word;
          bit_cnt_d = BIT_W'(1);
        end else begin
          state_d   = DELAY;
          bit_cnt_d = '0;
        end
      end else begin
        case (state_q)
          DELAY: begin
            state_d   = SHIFT;
            shreg_d   = shift_word;
            bit_cnt_d = BIT_W'(1);
          end
          SHIFT: begin
            if (capture) shreg_d = shift_word;
            if (bit_cnt_q == BIT_W'(SLOT_W - 1)) begin
              data_d    = capture ? shift_word : shreg_q;
              ch_d      = half_q ? (CH_W'(HALF) + slot_cnt_q) : slot_cnt_q;
              stb_d     = 1'b1;
              bit_cnt_d = '0;
              if (slot_cnt_q == CH_W'(HALF - 1)) begin
                state_d = HOLD;
              end else begin
                slot_cnt_d = slot_cnt_q + CH_W'(1);
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
          IDLE:    ;
          HOLD:    ;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lrck_q     <= 1'b0;
      half_q     <= 1'b0;
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lrck_q     <= lrck_d;
      half_q     <= half_d;
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      stb_q      <= stb_d;
    end
  end

  assign data_o     = data_q;
  assign ch_o       = ch_q;
  assign data_stb_o = stb_q;

`ifdef TDM_FRAME_CHECK_EN
  logic [1:0] hold_cnt_q, hold_cnt_d;
  logic       err_q, err_d;

  // Short half-frame: edge while mid-slot. Long: a second idle rise in HOLD.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    err_d      = 1'b0;
    if (lrck_edge) begin
      hold_cnt_d = '0;
      err_d      = (state_q == SHIFT);
    end else if (rise && state_q == HOLD) begin
      if (hold_cnt_q != 2'd2) hold_cnt_d = hold_cnt_q + 2'd1;
      err_d = (hold_cnt_q == 2'd1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
    end
  end

  assign frame_err_o = err_q;
`endif

endmodule
